timer_controller: RTL
=====================

// Module: timer_controller
// PURPOSE
//  Sequencer for the MM:SS countdown chain built from mod-10/mod-6 digit counters.
//  Captures keypad digits into a BCD preset, issues the load pulse, and generates the
//  1-cycle count-enable tick at 1 Hz equivalent. Stops the chain at 00:00 and flags done.
//  Sits between keypad/buttons and the four-digit counter chain; the chain reports zero back.
// PARAMETERS
//  TICK_DIV  100  clk cycles per countdown tick (>=2)
//  DIV_W     7    prescaler width, 2**DIV_W >= TICK_DIV
// PORTS
//  clk        in   1   system clock, rising edge
//  clear      in   1   reset, asynchronous, active-high
//  key_valid  in   1   1-cycle strobe: key_digit is valid
//  key_digit  in   4   keypad value, BCD
//  start      in   1   start/resume/acknowledge, level sampled per cycle
//  stop       in   1   pause/cancel/acknowledge, level sampled per cycle
//  zero       in   1   counter chain currently reads 00:00
//  load       out  1   1-cycle pulse: chain loads preset
//  preset     out  16  BCD {min_t, min_u, sec_t, sec_u}
//  en         out  1   1-cycle count-down tick to chain
//  running    out  1   high in RUN
//  done       out  1   high in DONE
// BEHAVIOUR
//  Reset (clear=1, async): state IDLE, preset=0, prescaler=0, load=en=running=done=0.
//  All outputs registered; they change only on clk rise (except async reset).
//  States: IDLE, RUN, PAUSE, DONE.
//  IDLE: key_valid & key_digit<=9 -> preset <= {preset[11:0], key_digit}; digits >9 ignored.
//   start & !stop & preset!=0 & preset[7:4]<=5 -> load=1 for exactly one cycle,
//   prescaler<=0, -> RUN. Invalid or zero preset: start ignored, stay IDLE.
//  RUN: running=1; keys ignored. Prescaler counts 0..TICK_DIV-1, wraps to 0.
//   en=1 for the cycle after prescaler reaches TICK_DIV-1, only if zero=0.
//   First en occurs TICK_DIV cycles after the load pulse cycle.
//   zero=1 (sampled, not in the load cycle) -> DONE; no en issued on that tick.
//   stop -> PAUSE; prescaler holds its value; pending en suppressed.
//  PAUSE: prescaler frozen. start & !stop -> RUN (no load, prescaler resumes).
//   stop -> IDLE, preset <= 0 (cancel).
//  DONE: done=1. start or stop -> IDLE, preset retained (restart without re-entry).
//  Simultaneous start & stop: stop wins in every state.
//  load and en never asserted in the same cycle; en never asserted outside RUN.
//  Reset mid-RUN: immediate return to IDLE values; chain contents not our concern.
// STRUCTURE
//  timer_pkg: state enum/encoding, BCD digit width 4, MAX_SEC_TENS=5, PRESET_W=16.
//  Sub-module tick_prescaler: mod-TICK_DIV up counter with clr, en, tc output
//   (same shape as the digit counters); FSM + preset shift register in top level.
// TESTING (bench uses TICK_DIV=4)
//  1 Reset: clear=1 mid-sim -> all outputs 0, preset=16'h0000 immediately, no clk needed.
//  2 Entry: keys 1,2,3,0 -> preset=16'h1230; key 4'hB -> preset unchanged.
//  3 Start: preset 16'h0002, start 1 cycle -> load 1 cycle, en every 4 cycles, first
//    en 4 cycles after load; model chain: zero after 2 en -> done=1, no 3rd en.
//  4 Invalid: preset 16'h0070 or 16'h0000, start -> no load, state IDLE, running=0.
//  5 Pause: stop 2 cycles after an en -> en stops; start -> next en 2 cycles later
//    (prescaler held); stop in PAUSE -> IDLE, preset=0.
//  6 Conflict: start&stop together in IDLE and RUN -> stop wins (no load; RUN->PAUSE);
//    DONE + start -> IDLE with preset retained, second start reloads same value.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown sequencer.
package timer_pkg;

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned PRESET_W = 16;

    localparam logic [DIGIT_W-1:0] MAX_DIGIT    = 4'd9;
    localparam logic [DIGIT_W-1:0] MAX_SEC_TENS = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A preset can be started when it is non-zero and its seconds-tens digit is 0..5.
    function automatic logic preset_ok(input logic [PRESET_W-1:0] p);
        return (p != '0) && (p[7:4] <= MAX_SEC_TENS);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Mod-TICK_DIV up counter with synchronous clear and count enable; tc marks the last count.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 100,
    parameter int unsigned DIV_W    = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    assign tc = (count_q == DIV_W'(TICK_DIV - 1));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/timer_controller.sv
// Countdown sequencer: keypad preset capture, chain load pulse, 1-tick count enable,
// and stop at 00:00 with a done flag.
module timer_controller
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100,
    parameter int unsigned DIV_W    = 7
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                key_valid,
    input  logic [DIGIT_W-1:0]  key_digit,
    input  logic                start,
    input  logic                stop,
    input  logic                zero,
    output logic                load,
    output logic [PRESET_W-1:0] preset,
    output logic                en,
    output logic                running,
    output logic                done
);

    state_t              state_q, state_d;
    logic [PRESET_W-1:0] preset_q, preset_d;
    logic                load_q, load_d;
    logic                en_q, en_d;
    logic                running_q, running_d;
    logic                done_q, done_d;

    logic presc_clr;
    logic presc_en;
    logic presc_tc;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_prescaler (
        .clk (clk),
        .rst (clear),
        .clr (presc_clr),
        .en  (presc_en),
        .tc  (presc_tc)
    );

    always_comb begin
        state_d   = state_q;
        preset_d  = preset_q;
        load_d    = 1'b0;
        en_d      = 1'b0;
        presc_clr = 1'b0;
        presc_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_valid && (key_digit <= MAX_DIGIT)) begin
                    preset_d = {preset_q[PRESET_W-DIGIT_W-1:0], key_digit};
                end
                if (start && !stop && preset_ok(preset_q)) begin
                    load_d    = 1'b1;
                    presc_clr = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                // zero is ignored during the load cycle: the chain still shows its old contents.
                if (stop) begin
                    state_d = ST_PAUSE;
                end else if (zero && !load_q) begin
                    state_d = ST_DONE;
                end else begin
                    presc_en = 1'b1;
                    en_d     = presc_tc && !zero;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d  = ST_IDLE;
                    preset_d = '0;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start || stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            preset_q  <= '0;
            load_q    <= 1'b0;
            en_q      <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            preset_q  <= preset_d;
            load_q    <= load_d;
            en_q      <= en_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign load    = load_q;
    assign preset  = preset_q;
    assign en      = en_q;
    assign running = running_q;
    assign done    = done_q;

endmodule
